// File: rtl/sample_stream_pkg.sv
// Shared widths and FSM state encoding for the sample stream burst source.
package sample_stream_pkg;

  localparam int unsigned DefDataWidth  = 8;
  localparam int unsigned DefLenWidth   = 8;
  localparam int unsigned DefGapWidth   = 4;
  localparam int unsigned DefStallWidth = 16;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StSend = 2'd1;
  localparam state_t StGap  = 2'd2;
  localparam state_t StDone = 2'd3;

endpackage

// File: rtl/sample_stream_source.sv
// Burst producer: incrementing-byte beats on a valid/ready stream with optional
// idle gaps and per-burst beat and stall statistics. All outputs are registered.
module sample_stream_source
  import sample_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned LEN_WIDTH   = DefLenWidth,
  parameter int unsigned GAP_WIDTH   = DefGapWidth,
  parameter int unsigned STALL_WIDTH = DefStallWidth
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   burst_len,
  input  logic [DATA_WIDTH-1:0]  start_value,
  input  logic [GAP_WIDTH-1:0]   gap_cycles,
  input  logic                   stream_out_ready,
  output logic                   stream_out_valid,
  output logic [DATA_WIDTH-1:0]  stream_out_data,
  output logic                   stream_out_last,
  output logic                   busy,
  output logic                   done,
  output logic [LEN_WIDTH-1:0]   beats_sent,
  output logic [STALL_WIDTH-1:0] stall_cycles
);

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d;
  logic [GAP_WIDTH-1:0]   timer_q, timer_d;
  logic                   valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [LEN_WIDTH-1:0]   beats_q, beats_d;
  logic [STALL_WIDTH-1:0] stall_q, stall_d;
  logic [LEN_WIDTH-1:0]   beats_inc;

  assign beats_inc = beats_q + 1'b1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    gap_d   = gap_q;
    timer_d = timer_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    beats_d = beats_q;
    stall_d = stall_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          beats_d = '0;
          stall_d = '0;
          if (burst_len != '0) begin
            len_d   = burst_len;
            gap_d   = gap_cycles;
            data_d  = start_value;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            last_d  = (burst_len == LEN_WIDTH'(1));
            state_d = StSend;
          end else begin
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StSend: begin
        if (stream_out_ready) begin
          beats_d = beats_inc;
          data_d  = data_q + 1'b1;
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else if (gap_q == '0) begin
            last_d = (beats_inc == len_q - 1'b1);
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            timer_d = gap_q;
            state_d = StGap;
          end
        end else if (stall_q != '1) begin
          stall_d = stall_q + 1'b1;
        end
      end
      StGap: begin
        // The timer reaches 1 on the last idle cycle, so the beat reappears after exactly gap cycles.
        if (timer_q == GAP_WIDTH'(1)) begin
          valid_d = 1'b1;
          last_d  = (beats_q == len_q - 1'b1);
          state_d = StSend;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      gap_q   <= '0;
      timer_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      beats_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      beats_q <= beats_d;
      stall_q <= stall_d;
    end
  end

  assign stream_out_valid = valid_q;
  assign stream_out_data  = data_q;
  assign stream_out_last  = last_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign beats_sent       = beats_q;
  assign stall_cycles     = stall_q;

endmodule
